mul_share_arb: RTL

Two-requester controller that shares a single W×W unsigned multiplier between independent clients using valid/ready handshakes. It sits in front of the multiplier datapath and does three things: arbitrates between pending requests, registers the winner's operands, and returns the registered 2W-bit product to the requester that issued it. One operation is in flight at a time, so the block trades throughput for a single shared multiplier.

---
 rtl/mul_share_arb.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb: two-requester valid/ready front end for a single shared
// W x W unsigned multiplier. One operation is in flight at a time:
// IDLE arbitrates and latches operands, MUL forms the full 2W-bit product,
// HOLD presents it to the issuing requester until it is consumed.
//
// Optional feature macro: MUL_ARB_ROUND_ROBIN_EN
//   defined   -> ties in IDLE alternate using a 1-bit last_grant register
//   undefined -> fixed priority, requester 0 wins every tie
module mul_share_arb #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [2*W-1:0]   rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               id_r;
    logic [2*W-1:0]     rsp_data_r;
    logic               rsp0_valid_r;
    logic               rsp1_valid_r;
    logic               busy_r;
    logic               grant0_s;
    logic               grant1_s;
    logic               accept_s;
    logic               rsp_take_s;
    logic [2*W-1:0]     prod_s;

`ifdef MUL_ARB_ROUND_ROBIN_EN
    logic               last_grant_r;

    // Arbitration: alternate on ties, a lone requester always wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Remember who was served last; reset value makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= grant1_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Arbitration: fixed priority, requester 0 wins whenever it is valid.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end
`endif

    // Readies are the grants themselves; a grant only exists while a valid is high.
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign accept_s   = grant0_s | grant1_s;

    // Only the latched requester's response ready can release HOLD.
    assign rsp_take_s = id_r ? rsp1_ready : rsp0_ready;

    // Full-width product; operands widened first so nothing is truncated.
    assign prod_s = {{W{1'b0}}, a_r} * {{W{1'b0}}, b_r};

    // Next-state logic for the IDLE -> MUL -> HOLD sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = MUL;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                state_s = HOLD;
            end
            HOLD: begin
                if (rsp_take_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, operand capture, product register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            a_r          <= '0;
            b_r          <= '0;
            id_r         <= 1'b0;
            rsp_data_r   <= '0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                a_r  <= grant1_s ? req1_a : req0_a;
                b_r  <= grant1_s ? req1_b : req0_b;
                id_r <= grant1_s;
            end else begin
                a_r  <= a_r;
                b_r  <= b_r;
                id_r <= id_r;
            end
            if (state_r == MUL) begin
                rsp_data_r <= prod_s;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
            // id_r is stable from accept through HOLD, so it steers the valids.
            rsp0_valid_r <= (state_s == HOLD) && (id_r == 1'b0);
            rsp1_valid_r <= (state_s == HOLD) && (id_r == 1'b1);
            busy_r       <= (state_s != IDLE);
        end
    end

    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp_data   = rsp_data_r;
    assign busy       = busy_r;

endmodule
